// File: rtl/split_pkg.sv
// Shared types and constants for the split_4ph router.
// SPLIT_SYNC_EN selects the synchronized-input variant and its data settle delay.
package split_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_ACK  = 2'd1,
    OUT_REQ = 2'd2,
    OUT_RET = 2'd3
  } split_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

`ifdef SPLIT_SYNC_EN
  localparam logic [1:0] SETTLE_CYCLES = 2'd2;
`else
  localparam logic [1:0] SETTLE_CYCLES = 2'd0;
`endif

  function automatic logic pick(input logic sel, input logic a_val, input logic b_val);
    return (sel == SEL_B) ? b_val : a_val;
  endfunction

endpackage

// File: rtl/split_4ph_sync2.sv
// Parameterised-width 2-flop synchronizer, async active-low reset to zero.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // two-stage capture of the asynchronous inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/split_4ph.sv
// 1-to-2 router for 4-phase bundled-data channels: token on D goes to A (S=0) or B (S=1).
// Define SPLIT_SYNC_EN to synchronize S_req/D_req/A_ack/B_ack and add a data settle delay.
module split_4ph
  import split_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S_req,
  input  logic             S_data,
  output logic             S_ack,
  input  logic             D_req,
  input  logic [WIDTH-1:0] D_data,
  output logic             D_ack,
  output logic             A_req,
  output logic [WIDTH-1:0] A_data,
  input  logic             A_ack,
  output logic             B_req,
  output logic [WIDTH-1:0] B_data,
  input  logic             B_ack,
  output logic             proto_err
);

  logic s_req_v, d_req_v, a_ack_v, b_ack_v;

`ifdef SPLIT_SYNC_EN
  logic [3:0] sync_q;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({S_req, D_req, A_ack, B_ack}),
    .q     (sync_q)
  );

  assign {s_req_v, d_req_v, a_ack_v, b_ack_v} = sync_q;
`else
  assign s_req_v = S_req;
  assign d_req_v = D_req;
  assign a_ack_v = A_ack;
  assign b_ack_v = B_ack;
`endif

  split_state_t     state_r, state_s;
  logic             sel_r, sel_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic             s_ack_r, s_ack_s;
  logic             d_ack_r, d_ack_s;
  logic             a_req_r, a_req_s;
  logic             b_req_r, b_req_s;
  logic             err_r, err_s;
  logic [1:0]       settle_r, settle_s;

  logic sel_ack_s;
  logic unsel_ack_s;
  logic input_phase_s;

  assign sel_ack_s     = pick(sel_r, a_ack_v, b_ack_v);
  assign unsel_ack_s   = pick(sel_r, b_ack_v, a_ack_v);
  assign input_phase_s = (state_r == IDLE) || (state_r == IN_ACK);

  // next-state and next-output logic
  always_comb begin
    state_s  = state_r;
    sel_s    = sel_r;
    data_s   = data_r;
    s_ack_s  = s_ack_r;
    d_ack_s  = d_ack_r;
    a_req_s  = a_req_r;
    b_req_s  = b_req_r;
    settle_s = settle_r;
    err_s    = err_r
             | (input_phase_s & sel_ack_s)
             | (~input_phase_s & unsel_ack_s);

    case (state_r)
      IDLE: begin
        if (s_req_v && d_req_v) begin
          sel_s    = S_data;
          data_s   = D_data;
          s_ack_s  = (SETTLE_CYCLES == 2'd0);
          d_ack_s  = (SETTLE_CYCLES == 2'd0);
          settle_s = SETTLE_CYCLES;
          state_s  = IN_ACK;
        end else begin
          state_s = IDLE;
        end
      end
      IN_ACK: begin
        // acks stay low until the latched bundle has had its settle cycles
        if (settle_r != 2'd0) begin
          settle_s = settle_r - 2'd1;
          s_ack_s  = (settle_r == 2'd1);
          d_ack_s  = (settle_r == 2'd1);
        end else if (!s_req_v && !d_req_v) begin
          s_ack_s = 1'b0;
          d_ack_s = 1'b0;
          a_req_s = (sel_r == SEL_A);
          b_req_s = (sel_r == SEL_B);
          state_s = OUT_REQ;
        end else begin
          state_s = IN_ACK;
        end
      end
      OUT_REQ: begin
        if (sel_ack_s) begin
          a_req_s = 1'b0;
          b_req_s = 1'b0;
          state_s = OUT_RET;
        end else begin
          state_s = OUT_REQ;
        end
      end
      OUT_RET: begin
        if (!sel_ack_s) begin
          state_s = IDLE;
        end else begin
          state_s = OUT_RET;
        end
      end
      default: begin
        s_ack_s = 1'b0;
        d_ack_s = 1'b0;
        a_req_s = 1'b0;
        b_req_s = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      sel_r    <= SEL_A;
      data_r   <= {WIDTH{1'b0}};
      s_ack_r  <= 1'b0;
      d_ack_r  <= 1'b0;
      a_req_r  <= 1'b0;
      b_req_r  <= 1'b0;
      err_r    <= 1'b0;
      settle_r <= 2'd0;
    end else begin
      state_r  <= state_s;
      sel_r    <= sel_s;
      data_r   <= data_s;
      s_ack_r  <= s_ack_s;
      d_ack_r  <= d_ack_s;
      a_req_r  <= a_req_s;
      b_req_r  <= b_req_s;
      err_r    <= err_s;
      settle_r <= settle_s;
    end
  end

  assign S_ack     = s_ack_r;
  assign D_ack     = d_ack_r;
  assign A_req     = a_req_r;
  assign B_req     = b_req_r;
  assign A_data    = data_r;
  assign B_data    = data_r;
  assign proto_err = err_r;

endmodule

// File: tb/tb_split_4ph.sv
// Self-checking bench for split_4ph: directed handshakes plus random tokens vs a queue model.
module tb_split_4ph;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       S_req = 1'b0, S_data = 1'b0, S_ack;
  logic       D_req = 1'b0, D_ack;
  logic [7:0] D_data = 8'h00;
  logic       A_req, A_ack = 1'b0, B_req, B_ack = 1'b0;
  logic [7:0] A_data, B_data;
  logic       proto_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  split_4ph #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_req(S_req), .S_data(S_data), .S_ack(S_ack),
    .D_req(D_req), .D_data(D_data), .D_ack(D_ack),
    .A_req(A_req), .A_data(A_data), .A_ack(A_ack),
    .B_req(B_req), .B_data(B_data), .B_ack(B_ack),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return S_ack;
      1: return D_ack;
      2: return A_req;
      3: return B_req;
      default: return 1'bx;
    endcase
  endfunction

  // step until the chosen output reaches val, bounded to 20 cycles
  task automatic wait_for(input int which, input logic val, input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (sig(which) !== val && n < 20);
    check(tag, {31'd0, sig(which)}, {31'd0, val});
  endtask

  task automatic in_phase(input logic sel, input logic [7:0] data, input int skew,
                          input bit lat, input bit jitter);
    int n;
    S_req = 1'b1;
    S_data = sel;
    for (int i = 0; i < skew; i++) begin
      step();
      check("s_ack_held_for_d", {31'd0, S_ack}, 32'd0);
    end
    D_req = 1'b1;
    D_data = data;
    if (sel) qb.push_back(data); else qa.push_back(data);
    wait_for(0, 1'b1, "s_ack_rise", n);
    check("d_ack_with_s_ack", {31'd0, D_ack}, 32'd1);
    if (lat) check("ack_latency", n, 32'd1);
    if (jitter) repeat ($urandom_range(0, 2)) step();
    S_req = 1'b0;
    D_req = 1'b0;
    D_data = 8'($urandom);
    wait_for(0, 1'b0, "s_ack_fall", n);
    check("d_ack_fall", {31'd0, D_ack}, 32'd0);
    check("out_req_with_ack_fall", {31'd0, sig(2 + int'(sel))}, 32'd1);
    check("unsel_req_low", {31'd0, sig(3 - int'(sel))}, 32'd0);
    if (lat) check("out_req_latency", n, 32'd1);
  endtask

  task automatic out_phase(input logic sel, input bit lat, input bit jitter);
    int n;
    logic [7:0] exp;
    logic [7:0] obs;
    if (sel) begin
      check("model_b_nonempty", {31'd0, qb.size() > 0}, 32'd1);
      exp = qb.pop_front();
      obs = B_data;
    end else begin
      check("model_a_nonempty", {31'd0, qa.size() > 0}, 32'd1);
      exp = qa.pop_front();
      obs = A_data;
    end
    check(sel ? "b_data" : "a_data", {24'd0, obs}, {24'd0, exp});
    if (jitter) repeat ($urandom_range(0, 2)) step();
    if (sel) B_ack = 1'b1; else A_ack = 1'b1;
    wait_for(2 + int'(sel), 1'b0, "out_req_fall", n);
    check("unsel_req_still_low", {31'd0, sig(3 - int'(sel))}, 32'd0);
    if (lat) check("req_fall_latency", n, 32'd1);
    if (sel) B_ack = 1'b0; else A_ack = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] rd;
    // reset state
    step();
    check("rst_s_ack", {31'd0, S_ack}, 32'd0);
    check("rst_d_ack", {31'd0, D_ack}, 32'd0);
    check("rst_a_req", {31'd0, A_req}, 32'd0);
    check("rst_b_req", {31'd0, B_req}, 32'd0);
    check("rst_a_data", {24'd0, A_data}, 32'd0);
    check("rst_b_data", {24'd0, B_data}, 32'd0);
    check("rst_err", {31'd0, proto_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // route to A, minimum-latency handshake throughout
    in_phase(1'b0, 8'h2A, 0, 1'b1, 1'b0);
    out_phase(1'b0, 1'b1, 1'b0);
    // route to B
    in_phase(1'b1, 8'hFF, 0, 1'b1, 1'b0);
    out_phase(1'b1, 1'b1, 1'b0);
    // skewed input reqs
    in_phase(1'b1, 8'h5C, 5, 1'b0, 1'b0);
    out_phase(1'b1, 1'b0, 1'b0);

    // 32 back-to-back random tokens with alternating select
    for (int i = 0; i < 32; i++) begin
      rd = 8'($urandom);
      in_phase(i[0], rd, 0, 1'b0, 1'b1);
      out_phase(i[0], 1'b0, 1'b1);
    end
    check("random_no_err", {31'd0, proto_err}, 32'd0);
    check("qa_drained", qa.size(), 32'd0);
    check("qb_drained", qb.size(), 32'd0);

    // unselected ack during OUT_REQ sets the sticky error
    in_phase(1'b0, 8'h33, 0, 1'b0, 1'b0);
    B_ack = 1'b1;
    step();
    B_ack = 1'b0;
    check("err_set", {31'd0, proto_err}, 32'd1);
    check("a_req_kept", {31'd0, A_req}, 32'd1);
    step();
    check("err_sticky", {31'd0, proto_err}, 32'd1);
    out_phase(1'b0, 1'b0, 1'b0);
    check("err_after_xfer", {31'd0, proto_err}, 32'd1);

    // reset while in OUT_REQ, then a normal token
    in_phase(1'b0, 8'hC3, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_a_req", {31'd0, A_req}, 32'd0);
    check("midrst_s_ack", {31'd0, S_ack}, 32'd0);
    check("midrst_err", {31'd0, proto_err}, 32'd0);
    check("midrst_a_data", {24'd0, A_data}, 32'd0);
    qa.delete();
    step();
    rst_n = 1'b1;
    step();
    in_phase(1'b0, 8'h00, 0, 1'b1, 1'b0);
    out_phase(1'b0, 1'b1, 1'b0);
    check("post_rst_b_req", {31'd0, B_req}, 32'd0);
    check("post_rst_err", {31'd0, proto_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
